// File: rtl/calc_pkg.sv
// Shared keypad/calculator types and constants.
package calc_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } scan_state_t;

  localparam logic [3:0] COL_FIRST = 4'b1110;
  localparam logic [3:0] ROW_IDLE  = 4'b1111;
  localparam logic [7:0] KEY_NONE  = 8'hFF;

  // Rotate the one-cold column drive to the next column: 1110 -> 1101 -> 1011 -> 0111.
  function automatic logic [3:0] col_next(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side signal bundle: row sense in, column drive and keystroke results out.
interface keypad_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [7:0] keystroke;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row_in,
    output col_out, keystroke, key_valid, key_held
  );

  modport slave (
    output row_in,
    input  col_out, keystroke, key_valid, key_held
  );
endinterface

// File: rtl/keypad_scanner_row_sync.sv
// Parameterizable two-flop synchronizer; resets to all-ones (idle level of pulled-up lines).
module row_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: one-cold column drive, synchronized row sampling,
// press/release debounce and a one-cycle keystroke strobe.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 50000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  keypad_scanner_if.master kp
);

  localparam int unsigned CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DWELL_END = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_END    = CW'(DEBOUNCE_CYCLES - 1);

  scan_state_t   r_state, w_state;
  logic [CW-1:0] r_dwell, w_dwell;
  logic [CW-1:0] r_db, w_db;
  logic [3:0]    r_col, w_col;
  logic [3:0]    r_row_cap, w_row_cap;
  logic [3:0]    r_col_cap, w_col_cap;
  logic [7:0]    r_keystroke, w_keystroke;
  logic          r_valid, w_valid;
  logic          r_held, w_held;
  logic [3:0]    w_rs;

  // A real press pulls exactly one row low; more than one is a ghost/multi-key.
  function automatic logic one_zero(input logic [3:0] v);
    int unsigned zeros;
    zeros = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!v[i]) zeros++;
    end
    return (zeros == 1);
  endfunction

  row_sync #(.WIDTH(4)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .i_d (kp.row_in),
    .o_q (w_rs)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SCAN;
      r_dwell     <= '0;
      r_db        <= '0;
      r_col       <= COL_FIRST;
      r_row_cap   <= ROW_IDLE;
      r_col_cap   <= COL_FIRST;
      r_keystroke <= KEY_NONE;
      r_valid     <= 1'b0;
      r_held      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_dwell     <= w_dwell;
      r_db        <= w_db;
      r_col       <= w_col;
      r_row_cap   <= w_row_cap;
      r_col_cap   <= w_col_cap;
      r_keystroke <= w_keystroke;
      r_valid     <= w_valid;
      r_held      <= w_held;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_dwell     = r_dwell;
    w_db        = r_db;
    w_col       = r_col;
    w_row_cap   = r_row_cap;
    w_col_cap   = r_col_cap;
    w_keystroke = r_keystroke;
    w_valid     = 1'b0;

    unique case (r_state)
      SCAN: begin
        if (r_dwell == DWELL_END) begin
          w_dwell = '0;
          if (one_zero(w_rs)) begin
            w_state   = DEBOUNCE;
            w_row_cap = w_rs;
            w_col_cap = r_col;
            w_db      = '0;
          end else begin
            w_col = col_next(r_col);
          end
        end else begin
          w_dwell = r_dwell + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (w_rs != r_row_cap) begin
          w_state = SCAN;
          w_col   = col_next(r_col);
          w_db    = '0;
        end else if (r_db == DB_END) begin
          w_state     = HELD;
          w_keystroke = {r_row_cap, r_col_cap};
          w_valid     = 1'b1;
          w_db        = '0;
        end else begin
          w_db = r_db + 1'b1;
        end
      end

      HELD: begin
        // Release needs an unbroken run of idle rows; any activity restarts it.
        if (w_rs == ROW_IDLE) begin
          if (r_db == DB_END) begin
            w_state = SCAN;
            w_col   = col_next(r_col);
            w_db    = '0;
          end else begin
            w_db = r_db + 1'b1;
          end
        end else begin
          w_db = '0;
        end
      end

      default: w_state = SCAN;
    endcase

    w_held = (w_state == HELD);
  end

  assign kp.col_out   = r_col;
  assign kp.keystroke = r_keystroke;
  assign kp.key_valid = r_valid;
  assign kp.key_held  = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed scenarios plus random key activity
// compared cycle by cycle against a behavioural keypad/scanner model.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keypad_scanner_if kif ();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif)
  );

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  // Stimulus: either a raw row value or a physical keypad (pressed[r*4+c]).
  bit          raw_mode;
  logic [3:0]  raw_row;
  logic [15:0] pressed;

  // Model state: mode 0 = scanning, 1 = confirming a press, 2 = key held.
  int         m_mode, m_ci, m_dwell, m_db;
  logic [3:0] m_rowcap, m_s1, m_s2;
  logic [7:0] m_key;
  logic       m_valid;

  function automatic logic [3:0] col_of(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << i);
  endfunction

  function automatic logic [3:0] keypad_rows(input logic [15:0] p, input logic [3:0] col);
    logic [3:0] rows;
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (p[r*4+c] && !col[c]) rows[r] = 1'b0;
    return rows;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ci = 0; m_dwell = 0; m_db = 0;
    m_rowcap = 4'hF; m_s1 = 4'hF; m_s2 = 4'hF;
    m_key = 8'hFF; m_valid = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] rin);
    logic [3:0] rs;
    int zeros;
    rs = m_s2; m_s2 = m_s1; m_s1 = rin;
    m_valid = 1'b0;
    zeros = 0;
    for (int i = 0; i < 4; i++) if (rs[i] == 1'b0) zeros++;
    case (m_mode)
      0: begin
        if (m_dwell == SD - 1) begin
          m_dwell = 0;
          if (zeros == 1) begin
            m_mode = 1; m_rowcap = rs; m_db = 0;
          end else m_ci = (m_ci + 1) % 4;
        end else m_dwell++;
      end
      1: begin
        if (rs !== m_rowcap) begin
          m_mode = 0; m_ci = (m_ci + 1) % 4; m_db = 0;
        end else if (m_db == DB - 1) begin
          m_mode = 2; m_key = {m_rowcap, col_of(m_ci)}; m_valid = 1'b1; m_db = 0;
        end else m_db++;
      end
      default: begin
        if (rs == 4'hF) begin
          if (m_db == DB - 1) begin
            m_mode = 0; m_ci = (m_ci + 1) % 4; m_db = 0;
          end else m_db++;
        end else m_db = 0;
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    kif.row_in = raw_mode ? raw_row : keypad_rows(pressed, kif.col_out);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(kif.row_in);
    #1;
    if (kif.key_valid === 1'b1) pulses++;
    check("outputs{col,key,valid,held}",
          {kif.col_out, kif.keystroke, kif.key_valid, kif.key_held},
          {col_of(m_ci), m_key, m_valid, (m_mode == 2)});
    drive();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_col"},   kif.col_out,   4'b1110);
    check({tag, "_key"},   kif.keystroke, 8'hFF);
    check({tag, "_valid"}, kif.key_valid, 1'b0);
    check({tag, "_held"},  kif.key_held,  1'b0);
  endtask

  initial begin
    int n;
    rst = 1'b1; raw_mode = 1'b1; raw_row = 4'hF; pressed = '0;
    model_reset();
    drive();
    repeat (3) tick();
    check_reset_values("reset");
    rst = 1'b0;

    // Idle scan
    pulses = 0;
    repeat (40) tick();
    check("idle_pulses", pulses, 0);
    check("idle_key", kif.keystroke, 8'hFF);

    // Clean press of key 5 (row 1101, col 1101)
    raw_mode = 1'b0; pressed = 16'h0020; drive();
    pulses = 0;
    repeat (60) tick();
    check("key5_pulses", pulses, 1);
    check("key5_code", kif.keystroke, 8'b1101_1101);
    check("key5_held", kif.key_held, 1'b1);
    pressed = '0; drive();
    n = 0;
    do begin tick(); n++; end while (kif.key_held !== 1'b0 && n < 40);
    check("key5_release_cycles", n, 10);
    check("key5_resume_col", kif.col_out, 4'b1011);

    // Bouncing key 0 (row 1101, col 0111)
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      pressed = (i % 2 == 0) ? 16'h0080 : 16'h0000; drive();
      repeat (3) tick();
    end
    check("bounce_pulses", pulses, 0);
    pressed = 16'h0080; drive();
    repeat (60) tick();
    check("key0_pulses", pulses, 1);
    check("key0_code", kif.keystroke, 8'b1101_0111);
    pressed = '0; drive();
    repeat (30) tick();

    // Multi-key on column 1110 (rows 1100)
    pulses = 0;
    pressed = 16'h0011; drive();
    repeat (40) tick();
    check("multi_pulses", pulses, 0);
    check("multi_held", kif.key_held, 1'b0);
    pressed = '0; drive();
    repeat (5) tick();

    // Key 1 held long; key 5 added while held
    pulses = 0;
    pressed = 16'h0001; drive();
    for (int i = 0; i < 200; i++) begin
      if (i == 100) begin pressed = pressed | 16'h0020; drive(); end
      tick();
    end
    check("held_pulses", pulses, 1);
    check("held_code", kif.keystroke, 8'b1110_1110);
    pressed = 16'h0020; drive();
    pulses = 0;
    repeat (60) tick();
    check("after_release_pulses", pulses, 1);
    check("after_release_code", kif.keystroke, 8'b1101_1101);
    pressed = '0; drive();
    repeat (30) tick();

    // Reset four cycles into debounce
    pressed = 16'h0001; drive();
    n = 0;
    while (!(m_mode == 1 && m_db == 4) && n < 100) begin tick(); n++; end
    check("reach_debounce", (n < 100), 1'b1);
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_values("midreset");
    pulses = 0;
    repeat (3) tick();
    rst = 1'b0;
    pressed = '0; drive();
    repeat (20) tick();
    check("midreset_pulses", pulses, 0);

    // Random key activity
    for (int it = 0; it < 40; it++) begin
      int kind, dur;
      kind = int'($urandom_range(0, 3));
      dur  = int'($urandom_range(5, 80));
      raw_mode = (kind == 0 || kind == 3);
      raw_row  = 4'hF;
      pressed  = '0;
      if (kind >= 1) pressed[$urandom_range(0, 15)] = 1'b1;
      if (kind == 2) pressed[$urandom_range(0, 15)] = 1'b1;
      drive();
      for (int c = 0; c < dur; c++) begin
        if (kind == 3) begin raw_row = 4'($urandom); drive(); end
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the 4×4 calculator keypad and produces one debounced `{ROW, COLUMN}` keystroke code per key press. It drives the column lines one-cold, synchronizes and samples the row lines, debounces both press and release, and emits a one-cycle `key_valid` strobe. It sits directly upstream of the combinational keystroke-to-hex decoder, which consumes `keystroke`.

## Interface
- `SCAN_DIV`, 50000: clock cycles each column is driven before it is sampled (the dwell time).
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a press and to accept a release.
- `clk`  in  1  the single system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `row_in`  in  4  keypad row lines, active-low (pulled up), asynchronous to `clk`.
- `col_out`  out  4  keypad column drive, one-cold active-low.
- `keystroke`  out  8  `{row[3:0], col[3:0]}` of the last accepted key, active-low. Examples: key 1 = 8'b1110_1110; key 0 = 8'b1101_0111.
- `key_valid`  out  1  one-cycle strobe; `keystroke` is new and valid in the same cycle.
- `key_held`  out  1  high while an accepted key has not yet been released.

## Operation
- `row_in` passes through a 2-flop synchronizer. `rs` denotes the synchronized row value.
- Column sequence: 1110 → 1101 → 1011 → 0111 → 1110, wrapping around.
- A dwell counter counts 0..SCAN_DIV-1. `rs` is sampled only when the count equals SCAN_DIV-1 (settle time).
- A sample is a valid press only if `rs` has exactly one zero bit.
  - 1111 means no press.
  - Two or more zeros are ignored as a ghost/multi-key; scanning continues.
- States:
  - **SCAN**: rotate columns. On a valid sample, capture `row_cap=rs` and `col_cap=col_out`, hold the column frozen, clear the counter, and go to DEBOUNCE. Otherwise advance to the next column at dwell end.
  - **DEBOUNCE**: each cycle, `rs` must equal `row_cap`.
    - On a mismatch, return to SCAN at the next column.
    - When the count reaches DEBOUNCE_CYCLES-1, register `keystroke={row_cap,col_cap}`, pulse `key_valid`, and go to HELD.
  - **HELD**: column stays frozen. While `rs`==1111 the counter increments; any other value clears it. When the count reaches DEBOUNCE_CYCLES-1, go to SCAN at the next column.
- `key_held` = 1 in HELD.
- `keystroke` holds its value until the next accepted key. It is never cleared on release.
- Any new key pressed while in HELD is ignored. It is only detected after release, if it is still pressed.
- Counters are sized as $clog2 of the larger parameter. Comparisons are equality only; the counter never wraps past its terminal value.

## Timing
- Reset values:
  - `col_out`=4'b1110
  - `keystroke`=8'hFF
  - `key_valid`=0
  - `key_held`=0
  - state SCAN, all counters 0, synchronizer flops 4'hF.
- A reset asserted mid-debounce or in HELD aborts immediately to the reset values. No strobe is emitted.
- Synchronizer latency: 2 cycles from `row_in` to `rs`.
- DEBOUNCE is entered in cycle T+1, where T is the dwell-end sample cycle. `key_valid` is high in exactly cycle T+1+DEBOUNCE_CYCLES, for one cycle. `key_held` rises in the same cycle.
- `col_out` changes only on the cycle after dwell end in SCAN, or on the cycle after exit from DEBOUNCE or HELD.
- Full-keypad worst-case detection latency: 4·SCAN_DIV + 2 + DEBOUNCE_CYCLES + 1 cycles.
- All outputs are registered. There are no combinational paths from `row_in`.

## Structure
- Shared package `calc_pkg` holds:
  - `scan_state_t` enum {SCAN, DEBOUNCE, HELD}
  - `COL_FIRST`=4'b1110
  - `ROW_IDLE`=4'b1111
  - `KEY_NONE`=8'hFF
- Sub-module `row_sync`: parameterizable-width 2-flop synchronizer with asynchronous reset to all-ones. It is reused for any other asynchronous inputs on the board.
- The FSM, dwell counter and debounce counter live in `keypad_scanner`. The one-zero check is a local function.

## Test plan
Parameters for all scenarios: SCAN_DIV=4, DEBOUNCE_CYCLES=8.
- **Reset / idle scan:** hold `row_in`=1111 → `col_out` cycles 1110, 1101, 1011, 0111 with 4 cycles each and wraps; `keystroke`=8'hFF and `key_valid`=0 throughout.
- **Clean press of key 5:** drive row 1101 while `col_out`=1101 and hold it for 30 cycles → exactly one `key_valid` pulse, `keystroke`=8'b1101_1101, `key_held`=1; release → `key_held` falls after 8+2 idle cycles and scanning resumes at column 1011.
- **Bounce:** key 0 (row 1101, col 0111) toggled every 3 cycles for 20 cycles, then stable → no strobe during bouncing; a single strobe with `keystroke`=8'b1101_0111 after it stabilizes.
- **Multi-key:** rows 1100 on column 1110 → ignored, no strobe, `col_out` keeps rotating.
- **Held key:** key 1 held for 200 cycles → one strobe only; a second key pressed during HELD produces no strobe until key 1 is released.
- **Reset mid-debounce:** assert `rst` 4 cycles into DEBOUNCE → outputs return to their reset values immediately; no `key_valid` pulse.
